mem_access_unit: RTL and testbench

//  Memory-stage load/store unit. Consumes the MEM-stage pipeline register outputs (MemtoRegM, MemWriteM, Funct3M, ComputeResultM, WriteDataM).

---
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory req/ack bus between the load/store unit and memory
interface mem_access_unit_if;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAddr;
  logic [3:0]  DByteEn;
  logic [31:0] DWData;
  logic        DAck;
  logic [31:0] DRData;

  modport master (
    output DReq, DWe, DAddr, DByteEn, DWData,
    input  DAck, DRData
  );

  modport slave (
    input  DReq, DWe, DAddr, DByteEn, DWData,
    output DAck, DRData
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store unit: bus req/ack, byte lanes, load extension
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     MemtoRegM,
  input  logic                     MemWriteM,
  input  logic [2:0]               Funct3M,
  input  logic [31:0]              ComputeResultM,
  input  logic [31:0]              WriteDataM,
  mem_access_unit_if.master        dbus,
  output logic [31:0]              ReadDataM,
  output logic                     MemBusy,
  output logic                     MisalignedM,
  output logic                     BusErrM
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t      state, state_nxt;
  logic        access, is_store, fault, start, timed_out;
  logic [1:0]  lane;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;

  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [CW-1:0] to_cnt;

  logic [31:0] rd_shifted;
  logic [31:0] rd_ext;

  assign access   = MemWriteM | MemtoRegM;
  assign is_store = MemWriteM;
  assign lane     = ComputeResultM[1:0];

  // Stores only have B/H/W; unsigned variants and 011/11x are illegal for them.
  always_comb begin
    fault = 1'b0;
    case (Funct3M)
      3'b000:  fault = 1'b0;
      3'b001:  fault = lane[0];
      3'b010:  fault = |lane;
      3'b100:  fault = is_store;
      3'b101:  fault = is_store | lane[0];
      default: fault = 1'b1;
    endcase
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = WriteDataM;
    case (Funct3M[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << lane;
        wdata_nxt = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_nxt    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_nxt    = 4'b1111;
        wdata_nxt = WriteDataM;
      end
    endcase
  end

  assign start       = (state == IDLE) && access && !fault;
  assign MisalignedM = (state == IDLE) && access && fault;

  // An ack arriving in the final allowed cycle still wins over the timeout.
  assign timed_out = (TIMEOUT_CYCLES != 0) && (state == REQ) && !dbus.DAck && (to_cnt == TO_LAST);

  always_comb begin
    rd_shifted = dbus.DRData >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  rd_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  rd_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  rd_ext = {24'b0, rd_shifted[7:0]};
      3'b101:  rd_ext = {16'b0, rd_shifted[15:0]};
      default: rd_ext = dbus.DRData;
    endcase
  end

  always_comb begin
    state_nxt = state;
    MemBusy   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          MemBusy   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        MemBusy = 1'b1;
        if (dbus.DAck || timed_out) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET || state != REQ) to_cnt <= '0;
    else                       to_cnt <= to_cnt + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
    end else begin
      if (start) begin
        we_q    <= is_store;
        addr_q  <= {ComputeResultM[31:2], 2'b00} | {30'b0, lane};
        be_q    <= be_nxt;
        wdata_q <= wdata_nxt;
        f3_q    <= Funct3M;
      end
      BusErrM <= timed_out;
      if (state == REQ && dbus.DAck) ReadDataM <= rd_ext;
      else if (timed_out)            ReadDataM <= '0;
    end
  end

  assign dbus.DReq    = (state == REQ);
  assign dbus.DWe     = we_q;
  assign dbus.DAddr   = {addr_q[31:2], 2'b00};
  assign dbus.DByteEn = be_q;
  assign dbus.DWData  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a behavioural reference model
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MemtoRegM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ComputeResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemBusy, MisalignedM, BusErrM;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] last_rd = 32'h0;

  typedef struct { bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } req_t;
  typedef struct { logic [31:0] rd; bit berr; } rsp_t;
  req_t req_q[$];
  rsp_t rsp_q[$];

  mem_access_unit_if dbus();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ComputeResultM(ComputeResultM), .WriteDataM(WriteDataM),
    .dbus(dbus),
    .ReadDataM(ReadDataM), .MemBusy(MemBusy), .MisalignedM(MisalignedM), .BusErrM(BusErrM)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_fault(input bit st, input logic [2:0] f3, input logic [31:0] ad);
    bit legal;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((ad % nbytes(f3)) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] ad);
    int mask;
    mask = (1 << nbytes(f3)) - 1;
    return 4'(mask << (ad % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (nbytes(f3) == 1) return 32'(wd[7:0]) * 32'h01010101;
    if (nbytes(f3) == 2) return 32'(wd[15:0]) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] word);
    longint v;
    int bits;
    bits = 8 * nbytes(f3);
    v = longint'(word) >> (8 * (ad % 4));
    if (bits < 32) begin
      v = v % (64'd1 << bits);
      if (!f3[2] && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    end
    return v[31:0];
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      MemWriteM = 1'b0; MemtoRegM = 1'b0; Funct3M = 3'($urandom);
      ComputeResultM = $urandom; WriteDataM = $urandom;
      dbus.DAck = 1'($urandom); dbus.DRData = $urandom;
      @(negedge CLK);
      chk("idle_dreq", 32'(dbus.DReq), 0);
      chk("idle_busy", 32'(MemBusy), 0);
      chk("idle_rd_hold", ReadDataM, last_rd);
    end
  endtask

  task automatic run_op(input bit st, input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] rdata);
    rsp_t r;
    logic [31:0] prev_rd;
    tick();
    MemWriteM = st; MemtoRegM = ld; Funct3M = f3; ComputeResultM = addr; WriteDataM = wd;
    dbus.DAck = 1'b0; dbus.DRData = $urandom;
    if (m_fault(st, f3, addr)) begin
      @(negedge CLK);
      chk("fault_mis", 32'(MisalignedM), 1);
      chk("fault_busy", 32'(MemBusy), 0);
      chk("fault_dreq", 32'(dbus.DReq), 0);
      tick();
      MemWriteM = 1'b0; MemtoRegM = 1'b0;
      @(negedge CLK);
      chk("fault_dreq_after", 32'(dbus.DReq), 0);
      return;
    end
    req_q.push_back('{we: st, addr: {addr[31:2], 2'b00}, be: m_be(f3, addr), wd: m_wdata(f3, wd)});
    if (ack_at < TO) begin r.rd = m_load(f3, addr, rdata); r.berr = 1'b0; end
    else             begin r.rd = 32'h0;                   r.berr = 1'b1; end
    rsp_q.push_back(r);
    prev_rd = last_rd;
    last_rd = r.rd;
    @(negedge CLK);
    chk("idle_mis", 32'(MisalignedM), 0);
    chk("idle_start_busy", 32'(MemBusy), 1);
    chk("idle_start_dreq", 32'(dbus.DReq), 0);
    chk("idle_start_rd", ReadDataM, prev_rd);
    for (int k = 0; k < TO; k++) begin
      tick();
      ComputeResultM = $urandom; WriteDataM = $urandom; Funct3M = 3'($urandom);
      dbus.DAck = (k == ack_at);
      dbus.DRData = (k == ack_at) ? rdata : $urandom;
      @(negedge CLK);
      chk("req_dreq", 32'(dbus.DReq), 1);
      chk("req_busy", 32'(MemBusy), 1);
      if (k == ack_at) break;
    end
    tick();
    dbus.DAck = 1'($urandom); dbus.DRData = $urandom;
    MemWriteM = 1'($urandom); MemtoRegM = 1'($urandom);
    @(negedge CLK);
    chk("done_dreq", 32'(dbus.DReq), 0);
    chk("done_busy", 32'(MemBusy), 0);
  endtask

  task automatic reset_mid_req();
    tick();
    MemWriteM = 1'b0; MemtoRegM = 1'b1; Funct3M = 3'b010; ComputeResultM = 32'h300; WriteDataM = $urandom;
    dbus.DAck = 1'b0;
    req_q.push_back('{we: 1'b0, addr: 32'h300, be: 4'hF, wd: m_wdata(3'b010, WriteDataM)});
    @(negedge CLK);
    chk("rst_start_busy", 32'(MemBusy), 1);
    tick();
    @(negedge CLK);
    chk("rst_req1_dreq", 32'(dbus.DReq), 1);
    tick();
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_req2_dreq", 32'(dbus.DReq), 1);
    tick();
    RESET = 1'b0;
    MemWriteM = 1'b0; MemtoRegM = 1'b0;
    dbus.DAck = 1'b1; dbus.DRData = 32'hCAFEF00D;
    last_rd = 32'h0;
    @(negedge CLK);
    chk("rst_dreq", 32'(dbus.DReq), 0);
    chk("rst_busy", 32'(MemBusy), 0);
    chk("rst_rd", ReadDataM, 0);
    chk("rst_berr", 32'(BusErrM), 0);
    tick();
    dbus.DAck = 1'b0;
    @(negedge CLK);
    chk("rst_no_capture", ReadDataM, 0);
    chk("rst_no_berr", 32'(BusErrM), 0);
  endtask

  initial begin : monitor
    bit prev = 1'b0;
    req_t cur = '{we: 1'b0, addr: 32'h0, be: 4'h0, wd: 32'h0};
    rsp_t r;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        prev = 1'b0;
      end else begin
        if (dbus.DReq && !prev) begin
          if (req_q.size() == 0) chk("req_unexpected", 32'(dbus.DReq), 0);
          else cur = req_q.pop_front();
        end
        if (dbus.DReq) begin
          chk("bus_we", 32'(dbus.DWe), 32'(cur.we));
          chk("bus_addr", dbus.DAddr, cur.addr);
          chk("bus_be", 32'(dbus.DByteEn), 32'(cur.be));
          if (cur.we) chk("bus_wdata", dbus.DWData, cur.wd);
        end
        if (prev && !dbus.DReq) begin
          if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(prev), 0);
          else begin
            r = rsp_q.pop_front();
            chk("rsp_rdata", ReadDataM, r.rd);
            chk("rsp_buserr", 32'(BusErrM), 32'(r.berr));
          end
        end else begin
          chk("buserr_quiet", 32'(BusErrM), 0);
        end
        prev = dbus.DReq;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin : stim
    RESET = 1'b1;
    MemtoRegM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b0;
    ComputeResultM = 32'h0; WriteDataM = 32'h0;
    dbus.DAck = 1'b0; dbus.DRData = 32'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_dreq", 32'(dbus.DReq), 0);
    chk("reset_busy", 32'(MemBusy), 0);
    chk("reset_rd", ReadDataM, 0);
    chk("reset_berr", 32'(BusErrM), 0);
    chk("reset_we", 32'(dbus.DWe), 0);
    tick();
    RESET = 1'b0;

    run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    run_op(1'b0, 1'b1, 3'b000, 32'h203, 32'h0, 0, 32'h80FFFFFF);
    run_op(1'b0, 1'b1, 3'b100, 32'h203, 32'h0, 1, 32'h80FFFFFF);
    run_op(1'b0, 1'b1, 3'b101, 32'h202, 32'h0, 2, 32'h80FFFFFF);
    run_op(1'b1, 1'b0, 3'b000, 32'h41, 32'h123456AB, 0, 32'h0);
    run_op(1'b1, 1'b0, 3'b001, 32'h42, 32'h123456AB, 1, 32'h0);
    run_op(1'b1, 1'b1, 3'b010, 32'h80, 32'h55AA33CC, 0, 32'h0);
    idle(2);
    run_op(1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 0, 32'h0);
    run_op(1'b1, 1'b0, 3'b001, 32'h41, 32'h0, 0, 32'h0);
    run_op(1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 0, 32'h0);
    run_op(1'b1, 1'b0, 3'b100, 32'h100, 32'h0, 0, 32'h0);
    run_op(1'b0, 1'b1, 3'b010, 32'h104, 32'h0, TO, 32'h0);
    idle(1);
    run_op(1'b0, 1'b1, 3'b010, 32'h108, 32'h0, TO - 1, 32'h13579BDF);
    reset_mid_req();

    for (int i = 0; i < 200; i++) begin
      bit st, ld;
      st = 1'($urandom);
      ld = 1'($urandom);
      if (!st && !ld) ld = 1'b1;
      run_op(st, ld, 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, TO), $urandom);
      idle($urandom_range(0, 2));
    end

    idle(2);
    chk("req_q_empty", 32'(req_q.size()), 0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
